// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: keeps predicted branches in program order from
// dispatch to retire, checks branch-unit results against the prediction, raises
// a one-cycle flush/redirect on a mispredict (dropping every younger branch) and
// hands resolved branches to commit from the head of the queue.
module branch_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2,
  parameter int PC_W  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [PC_W-1:0]  dispatch_pc,
  input  logic             dispatch_pred_taken,
  input  logic [PC_W-1:0]  dispatch_pred_target,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic [PC_W-1:0]  resolve_target,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  input  logic             commit_ready,
  output logic             flush,
  output logic [TAG_W-1:0] flush_tag,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [TAG_W:0]   outstanding,
  output logic [15:0]      mispredict_count
);

  localparam int PTR_W = TAG_W + 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PTR_W-1:0] head_q, tail_q;

  // Per-entry status (reset) and payload (not reset).
  logic             valid_q       [DEPTH];
  logic             resolved_q    [DEPTH];
  logic [PC_W-1:0]  pc_q          [DEPTH];
  logic             pred_taken_q  [DEPTH];
  logic [PC_W-1:0]  pred_target_q [DEPTH];

  logic             flush_q;
  logic [TAG_W-1:0] flush_tag_q;
  logic [PC_W-1:0]  redirect_q;
  logic [15:0]      mp_count_q;

  logic [TAG_W-1:0] head_idx, tail_idx, res_off;
  logic             full;
  logic             mispredict_now, res_accept;
  logic             do_dispatch, do_commit, do_mispredict;
  logic [PC_W-1:0]  correct_pc;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

  // Comparison against the stored prediction; a not-taken branch only
  // mispredicts on direction, a taken one also on target.
  assign mispredict_now = (resolve_taken != pred_taken_q[resolve_tag]) ||
                          (resolve_taken && (resolve_target != pred_target_q[resolve_tag]));
  // Results for squashed, already-resolved or never-dispatched tags are dropped.
  assign res_accept     = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];
  assign do_mispredict  = res_accept && mispredict_now;
  assign correct_pc     = resolve_taken ? resolve_target : pc_q[resolve_tag] + PC_W'(4);
  // Age of the resolving branch relative to the head (0 = oldest).
  assign res_off        = resolve_tag - head_idx;

  // Dispatch is held off while a flush is pending or about to be raised, so
  // nothing can be written into a slot that the truncation is about to reuse.
  assign dispatch_ready = !full && !flush_q && !(resolve_valid && mispredict_now);
  assign dispatch_tag   = tail_idx;
  assign do_dispatch    = dispatch_valid && dispatch_ready;

  assign commit_valid   = valid_q[head_idx] && resolved_q[head_idx];
  assign commit_tag     = head_idx;
  assign do_commit      = commit_valid && commit_ready;

  assign outstanding      = tail_q - head_q;
  assign flush            = flush_q;
  assign flush_tag        = flush_tag_q;
  assign redirect_pc      = redirect_q;
  assign mispredict_count = mp_count_q;

  // Head advances on commit; tail advances on dispatch or is pulled back to
  // just past the mispredicted branch (truncation measured from the pre-commit head).
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every block sees
    // the pre-edge values regardless of evaluation order.
    if (RST) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (do_commit) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (do_mispredict) begin
        tail_q <= head_q + {1'b0, res_off} + PTR_W'(1);
      end else if (do_dispatch) begin
        tail_q <= tail_q + PTR_W'(1);
      end
    end
  end

  // Entry status: allocate on dispatch, mark on resolve, free on commit,
  // squash everything younger than a mispredicted branch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]    <= 1'b0;
        resolved_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_dispatch && (tail_idx == TAG_W'(i))) begin
          valid_q[i]    <= 1'b1;
          resolved_q[i] <= 1'b0;
        end
        if (res_accept && (resolve_tag == TAG_W'(i))) begin
          resolved_q[i] <= 1'b1;
        end
        if (do_commit && (head_idx == TAG_W'(i))) begin
          valid_q[i] <= 1'b0;
        end
        if (do_mispredict && ((TAG_W'(i) - head_idx) > res_off)) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Branch payload captured at dispatch.
  always_ff @(posedge CLK) begin
    // NOTE: payload storage has no reset; it is only read for entries whose
    // valid bit (which is reset) says it was written.
    if (do_dispatch) begin
      pc_q[tail_idx]          <= dispatch_pc;
      pred_taken_q[tail_idx]  <= dispatch_pred_taken;
      pred_target_q[tail_idx] <= dispatch_pred_target;
    end
  end

  // One-cycle flush pulse with redirect info, plus the saturating mispredict count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flush_q     <= 1'b0;
      flush_tag_q <= '0;
      redirect_q  <= '0;
      mp_count_q  <= '0;
    end else begin
      flush_q <= do_mispredict;
      if (do_mispredict) begin
        flush_tag_q <= resolve_tag;
        redirect_q  <= correct_pc;
        if (mp_count_q != 16'hFFFF) begin
          mp_count_q <= mp_count_q + 16'd1;
        end
      end
    end
  end

endmodule
